sync_downcounter_ld: RTL and testbench

- Synchronous down counter built from T flip-flops. It is the count-down counterpart of the team's synchronous up counter.
- Provides parallel load, count enable, programmable reload on underflow, and a combinational borrow-out so instances can be cascaded.
- Used as a timer or divider block alongside the existing counter library.

---
 rtl/sync_downcounter_ld_pkg.sv | 10 +
 rtl/sync_downcounter_ld_tff_arn.sv | 26 ++
 rtl/sync_downcounter_ld.sv | 59 +++++
 tb/tb_sync_downcounter_ld.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sync_downcounter_ld_pkg.sv
// Shared constants for the down-counter slice: default width, legal width range
// and the reset level seen by every flip-flop in the counter.
package sync_downcounter_ld_pkg;

  localparam int   DEFAULT_WIDTH = 4;
  localparam int   MIN_WIDTH     = 2;
  localparam int   MAX_WIDTH     = 16;
  localparam logic RST_LEVEL     = 1'b0;

endpackage

// File: rtl/sync_downcounter_ld_tff_arn.sv
// T flip-flop with asynchronous active-low reset to 0; qb is always ~q,
// including while reset is held.
module tff_arn
  import sync_downcounter_ld_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qb
);

  logic r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_LEVEL) begin
      r_q <= 1'b0;
    end else if (t) begin
      r_q <= ~r_q;
    end
  end

  assign q  = r_q;
  assign qb = ~r_q;

endmodule

// File: rtl/sync_downcounter_ld.sv
// Synchronous T-flip-flop down counter with parallel load, count enable,
// reload-on-underflow and a combinational borrow-out for cascading.
module sync_downcounter_ld
  import sync_downcounter_ld_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             t,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] rl,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             zero,
  output logic             bo
);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("sync_downcounter_ld: WIDTH out of range");
  end

  // w_lz[i]: every bit below i is zero (ripple of qb terms)
  logic [WIDTH-1:0] w_lz;
  logic [WIDTH-1:0] w_tog;
  logic             w_qz;
  logic             w_dec;
  logic             w_rld;

  assign w_lz[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_chain
    assign w_lz[i] = w_lz[i-1] & qb[i-1];
  end

  assign w_qz  = w_lz[WIDTH-1] & qb[WIDTH-1];
  assign w_dec = t & ~ld & ~w_qz;
  assign w_rld = t & ~ld & w_qz;

  // Each toggle term moves the bit to its next value: decrement, reload or load
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_tog[i] = (w_dec & w_lz[i])
                    | (w_rld & (q[i] ^ rl[i]))
                    | (ld    & (q[i] ^ d[i]));

    tff_arn u_tff (
      .clk (clk),
      .rst (rst),
      .t   (w_tog[i]),
      .q   (q[i]),
      .qb  (qb[i])
    );
  end

  assign zero = w_qz;
  assign bo   = w_rld;

endmodule

// File: tb/tb_sync_downcounter_ld.sv
// Scoreboard bench for sync_downcounter_ld: a behavioural model pushes the next
// expected count when stimulus is driven and the value is popped after the edge.
module tb_sync_downcounter_ld;

  logic       clk = 1'b0;
  logic       rst;
  logic       t, ld;
  logic [3:0] d, rl;
  logic [3:0] q, qb;
  logic       zero, bo;

  logic       c_t, c_ld;
  logic [7:0] c_d;
  logic [3:0] c_lo_q, c_lo_qb, c_hi_q, c_hi_qb;
  logic       c_lo_zero, c_lo_bo, c_hi_zero, c_hi_bo;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] m_q;
  logic [7:0] mc_q;
  logic [3:0] exp_q[$];
  logic [7:0] exp_c[$];

  always #5 clk = ~clk;

  sync_downcounter_ld #(.WIDTH(4)) u_dut (
    .clk (clk), .rst (rst), .t (t), .ld (ld), .d (d), .rl (rl),
    .q (q), .qb (qb), .zero (zero), .bo (bo)
  );

  sync_downcounter_ld #(.WIDTH(4)) u_lo (
    .clk (clk), .rst (rst), .t (c_t), .ld (c_ld), .d (c_d[3:0]), .rl (4'hF),
    .q (c_lo_q), .qb (c_lo_qb), .zero (c_lo_zero), .bo (c_lo_bo)
  );

  sync_downcounter_ld #(.WIDTH(4)) u_hi (
    .clk (clk), .rst (rst), .t (c_lo_bo), .ld (c_ld), .d (c_d[7:4]), .rl (4'hF),
    .q (c_hi_q), .qb (c_hi_qb), .zero (c_hi_zero), .bo (c_hi_bo)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input logic it, input logic ild, input logic [3:0] id, input logic [3:0] irl);
    logic [3:0] nq;
    t = it; ld = ild; d = id; rl = irl;
    #1;
    chk("qb", qb, 4'(~m_q));
    chk("zero", zero, 1'(m_q == 4'd0));
    chk("bo", bo, 1'(it & ~ild & (m_q == 4'd0)));
    if (ild)                nq = id;
    else if (it && m_q == 0) nq = irl;
    else if (it)            nq = m_q - 4'd1;
    else                    nq = m_q;
    exp_q.push_back(nq);
    @(posedge clk); #1;
    m_q = exp_q.pop_front();
    chk("q", q, m_q);
  endtask

  task automatic cstep(input logic it, input logic ild, input logic [7:0] id);
    logic [7:0] nq;
    c_t = it; c_ld = ild; c_d = id;
    #1;
    chk("c_borrow", c_lo_bo, 1'(it & ~ild & (mc_q[3:0] == 4'd0)));
    if (ild)     nq = id;
    else if (it) nq = mc_q - 8'd1;
    else         nq = mc_q;
    exp_c.push_back(nq);
    @(posedge clk); #1;
    mc_q = exp_c.pop_front();
    chk("c_q", {c_hi_q, c_lo_q}, mc_q);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] cd_seq [6];
    int pulses;
    cd_seq = '{4'h3, 4'h2, 4'h1, 4'h0, 4'hF, 4'hE};

    rst = 1'b0; t = 1'b1; ld = 1'b0; d = 4'h0; rl = 4'h9;
    c_t = 1'b0; c_ld = 1'b0; c_d = 8'h00;
    m_q = 4'h0; mc_q = 8'h00;

    // reset held with t high
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", q, 4'h0);
    chk("rst_qb", qb, 4'hF);
    chk("rst_zero", zero, 1'b1);
    chk("rst_bo", bo, 1'b1);

    // release: first edge reloads rl
    rst = 1'b1;
    step(1'b1, 1'b0, 4'h0, 4'h9);
    chk("rst_release_q", q, 4'h9);

    // modulo-10 divider
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (bo) pulses++;
      step(1'b1, 1'b0, 4'h0, 4'h9);
    end
    chk("div10_pulses", pulses, 1);
    chk("div10_wrap_q", q, 4'h9);

    // load then count through underflow with rl = F
    step(1'b0, 1'b1, 4'h3, 4'hF);
    for (int i = 0; i < 6; i++) begin
      chk("cd_seq", q, cd_seq[i]);
      step(1'b1, 1'b0, 4'h0, 4'hF);
    end
    chk("cd_end", q, 4'hD);

    // load beats underflow
    step(1'b0, 1'b1, 4'h0, 4'hF);
    step(1'b1, 1'b1, 4'h5, 4'hF);
    chk("prio_q", q, 4'h5);

    // rl = 0 sticks at zero
    step(1'b0, 1'b1, 4'h0, 4'h0);
    repeat (3) step(1'b1, 1'b0, 4'h0, 4'h0);
    chk("rl0_q", q, 4'h0);

    // hold with d/rl wiggling
    step(1'b0, 1'b1, 4'h6, 4'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'($urandom), 4'($urandom));
    chk("hold_q", q, 4'h6);

    // asynchronous reset between edges
    #3 rst = 1'b0;
    #1;
    chk("async_q", q, 4'h0);
    chk("async_qb", qb, 4'hF);
    chk("async_zero", zero, 1'b1);
    m_q = 4'h0;
    t = 1'bx; ld = 1'bx;
    repeat (2) @(posedge clk);
    #1;
    chk("x_in_rst_q", q, 4'h0);
    t = 1'b0; ld = 1'b0;
    rst = 1'b1;
    step(1'b0, 1'b0, 4'hA, 4'hB);

    // cascade of two nibbles
    mc_q = {c_hi_q, c_lo_q};
    chk("c_after_rst", mc_q, 8'h00);
    cstep(1'b0, 1'b1, 8'h01);
    chk("c_load", {c_hi_q, c_lo_q}, 8'h01);
    cstep(1'b1, 1'b0, 8'h00);
    chk("c_to_00", {c_hi_q, c_lo_q}, 8'h00);
    cstep(1'b1, 1'b0, 8'h00);
    chk("c_to_ff", {c_hi_q, c_lo_q}, 8'hFF);
    repeat (20) cstep(1'b1, 1'b0, 8'h00);
    chk("c_end", {c_hi_q, c_lo_q}, 8'hEB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
